// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU issue sequencer: default sizes, ALU
// operation codes and the sequencer state encoding.
package alu_sequencer_pkg;

  localparam int DEF_MEMORY_WORD_SIZE = 8;
  localparam int DEF_RAM_SIZE         = 256;
  localparam int DEF_OPERATOR_SIZE    = 2;

  localparam logic [1:0] ALU_OP_AND = 2'd0;
  localparam logic [1:0] ALU_OP_OR  = 2'd1;
  localparam logic [1:0] ALU_OP_XOR = 2'd2;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_RD_A  = 3'd1,
    SEQ_RD_B  = 3'd2,
    SEQ_LAT_B = 3'd3,
    SEQ_EXEC  = 3'd4,
    SEQ_WB    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Issue-side controller for the external combinational ALU. Accepts one
// command, reads both operands from the synchronous data RAM, presents
// them to the ALU from registers and writes the result back to dst.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int  MEMORY_WORD_SIZE = DEF_MEMORY_WORD_SIZE,
  parameter int  RAM_SIZE         = DEF_RAM_SIZE,
  parameter int  OPERATOR_SIZE    = DEF_OPERATOR_SIZE,
  localparam int ADDR_W           = $clog2(RAM_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [OPERATOR_SIZE-1:0]    cmd_op,
  input  logic [ADDR_W-1:0]           cmd_src_a,
  input  logic [ADDR_W-1:0]           cmd_src_b,
  input  logic [ADDR_W-1:0]           cmd_dst,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_rd_en,
  input  logic [MEMORY_WORD_SIZE-1:0] mem_rdata,
  output logic                        mem_wr_en,
  output logic [MEMORY_WORD_SIZE-1:0] mem_wdata,
  output logic [MEMORY_WORD_SIZE-1:0] alu_operand_a,
  output logic [MEMORY_WORD_SIZE-1:0] alu_operand_b,
  output logic [OPERATOR_SIZE-1:0]    alu_operation,
  input  logic [MEMORY_WORD_SIZE-1:0] alu_result,
  output logic                        busy,
  output logic                        done,
  output logic                        illegal_op,
  output logic [MEMORY_WORD_SIZE-1:0] last_result
);

  seq_state_t state, next_state;

  logic [OPERATOR_SIZE-1:0]    op_reg;
  logic [ADDR_W-1:0]           src_a_reg;
  logic [ADDR_W-1:0]           src_b_reg;
  logic [ADDR_W-1:0]           dst_reg;
  logic [MEMORY_WORD_SIZE-1:0] op_a;
  logic [MEMORY_WORD_SIZE-1:0] op_b;
  logic [MEMORY_WORD_SIZE-1:0] res;
  logic                        op_legal;

  assign op_legal = (op_reg == OPERATOR_SIZE'(ALU_OP_AND)) ||
                    (op_reg == OPERATOR_SIZE'(ALU_OP_OR))  ||
                    (op_reg == OPERATOR_SIZE'(ALU_OP_XOR));

  assign alu_operand_a = op_a;
  assign alu_operand_b = op_b;
  assign alu_operation = op_reg;

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SEQ_IDLE;
    else          state <= next_state;
  end

  // Walk the fixed read/execute/writeback sequence, one state per cycle.
  always_comb begin
    next_state = state;
    case (state)
      SEQ_IDLE:  if (cmd_valid) next_state = SEQ_RD_A;
      SEQ_RD_A:  next_state = SEQ_RD_B;
      SEQ_RD_B:  next_state = SEQ_LAT_B;
      SEQ_LAT_B: next_state = SEQ_EXEC;
      SEQ_EXEC:  next_state = SEQ_WB;
      SEQ_WB:    next_state = SEQ_IDLE;
      default:   next_state = SEQ_IDLE;
    endcase
  end

  // Datapath registers: command latch, operand capture, result and history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_reg      <= '0;
      src_a_reg   <= '0;
      src_b_reg   <= '0;
      dst_reg     <= '0;
      op_a        <= '0;
      op_b        <= '0;
      res         <= '0;
      last_result <= '0;
    end else begin
      if (state == SEQ_IDLE && cmd_valid) begin
        op_reg    <= cmd_op;
        src_a_reg <= cmd_src_a;
        src_b_reg <= cmd_src_b;
        dst_reg   <= cmd_dst;
      end
      if (state == SEQ_RD_B)  op_a <= mem_rdata;
      if (state == SEQ_LAT_B) op_b <= mem_rdata;
      if (state == SEQ_EXEC)  res  <= alu_result;
      if (state == SEQ_WB)    last_result <= op_legal ? res : '0;
    end
  end

  // Moore outputs decoded from state and registers only.
  always_comb begin
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    mem_addr   = '0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    mem_wdata  = '0;
    done       = 1'b0;
    illegal_op = 1'b0;
    case (state)
      SEQ_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      SEQ_RD_A: begin
        mem_rd_en = 1'b1;
        mem_addr  = src_a_reg;
      end
      SEQ_RD_B: begin
        mem_rd_en = 1'b1;
        mem_addr  = src_b_reg;
      end
      SEQ_WB: begin
        mem_addr   = dst_reg;
        mem_wr_en  = op_legal;
        mem_wdata  = res;
        done       = 1'b1;
        illegal_op = !op_legal;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issue-side controller for the combinational ALU.
- Accepts one command {op, src_a, src_b, dst} over a valid/ready handshake. Reads both operands from data RAM (synchronous read, 1-cycle latency) and drives the ALU operand/operation inputs from registers. Captures the ALU result and writes it back to RAM at dst.
- Sits between the instruction decode stage and the data RAM/ALU pair. The ALU stays a separate external instance.

Parameters:
- MEMORY_WORD_SIZE, `MEMORY_WORD_SIZE (8): data word width.
- RAM_SIZE, `RAM_SIZE (256): words in data RAM. ADDR_W = $clog2(RAM_SIZE).
- OPERATOR_SIZE, `OPERATOR_SIZE (2): ALU operation code width.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command (IDLE only)
- cmd_op  in  OPERATOR_SIZE  ALU operation code
- cmd_src_a  in  ADDR_W  RAM address of operand A
- cmd_src_b  in  ADDR_W  RAM address of operand B
- cmd_dst  in  ADDR_W  RAM address for the result
- mem_addr  out  ADDR_W  RAM address
- mem_rd_en  out  1  RAM read strobe
- mem_rdata  in  MEMORY_WORD_SIZE  RAM read data, valid the cycle after mem_rd_en
- mem_wr_en  out  1  RAM write strobe
- mem_wdata  out  MEMORY_WORD_SIZE  RAM write data
- alu_operand_a  out  MEMORY_WORD_SIZE  to ALU operandA (registered)
- alu_operand_b  out  MEMORY_WORD_SIZE  to ALU operandB (registered)
- alu_operation  out  OPERATOR_SIZE  to ALU operation (registered)
- alu_result  in  MEMORY_WORD_SIZE  from ALU result
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at command completion
- illegal_op  out  1  one-cycle pulse, coincident with done, when op is not AND/OR/XOR
- last_result  out  MEMORY_WORD_SIZE  last completed result, held until the next done

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0 except cmd_ready=1. Operand, operation and last_result registers are cleared to 0.
- Handshake: a command is accepted when cmd_valid && cmd_ready at a rising edge. cmd_* fields are latched into internal registers at that edge. cmd_valid during a busy state is ignored and must be held by the source.
- FSM, one state per cycle, accept edge = end of cycle 0:
  - IDLE: cmd_ready=1. On accept, go to RD_A.
  - RD_A (cycle 1): mem_rd_en=1, mem_addr=src_a.
  - RD_B (cycle 2): latch mem_rdata into op_a; mem_rd_en=1, mem_addr=src_b.
  - LAT_B (cycle 3): latch mem_rdata into op_b.
  - EXEC (cycle 4): ALU inputs are stable from registers. Capture alu_result into res at end of cycle.
  - WB (cycle 5): mem_wr_en=1, mem_addr=dst, mem_wdata=res; done=1; last_result updates at end of cycle; then IDLE.
- Latency: accept-to-done is 5 cycles. Throughput is one command per 6 cycles. No back-to-back accept in WB.
- alu_operation is latched at accept and held until the next accept. alu_operand_a/b follow op_a/op_b.
- Illegal op (code not `ALU_OP_AND/`ALU_OP_OR/`ALU_OP_XOR):
  - The sequence runs as normal, but mem_wr_en stays 0 in WB.
  - illegal_op=1 and done=1.
  - last_result is set to 8'h00, matching the ALU default.
- Aliasing:
  - src_a==src_b: two reads of the same word; legal.
  - dst==src_a or dst==src_b: legal, because the write follows both reads.
- mem_rd_en and mem_wr_en are never asserted in the same cycle.
- Reset mid-operation: abort immediately. No write is issued and no done pulse is generated; return to IDLE.
- Outputs are Moore-style, decoded from state and registers only. There is no combinational path from cmd_* to mem_* or alu_*.

Decomposition:
- Defs.vh (shared) holds:
  - `ALU_OP_AND=2'd0, `ALU_OP_OR=2'd1, `ALU_OP_XOR=2'd2
  - `MEMORY_WORD_SIZE, `RAM_SIZE, `OPERATOR_SIZE
  - sequencer state encodings `SEQ_IDLE..`SEQ_WB, 3 bits
- No sub-module. The FSM and datapath registers live in one module. ALU and RAM are instantiated by the parent.

Test Plan:
- Reset then idle: reset_n low then high -> cmd_ready=1, busy=0, all strobes 0, last_result=0.
- AND: RAM[3]=8'hF0, RAM[7]=8'h3C, cmd {AND,3,7,9} -> reads at cycles 1,2; write RAM[9]=8'h30 with done at cycle 5; last_result=8'h30.
- XOR with dst aliasing src_a: RAM[4]=8'hAA, RAM[5]=8'hFF, cmd {XOR,4,5,4} -> RAM[4]=8'h55 at cycle 5. A second XOR with the same command gives RAM[4]=8'hAA.
- Illegal op: cmd_op=2'd3 -> done=1 and illegal_op=1 at cycle 5; no mem_wr_en; last_result=8'h00.
- Busy ignore: hold cmd_valid high with a second command during cycles 1-5 -> not accepted until IDLE. The second command is accepted at cycle 6, and its done arrives at cycle 11.
- Reset mid-op: assert reset_n low in EXEC -> no write to dst, no done pulse; IDLE with cmd_ready=1 after release.
